// File: rtl/video_pkg.sv
// video_pkg: shared raster-timing definitions for the HDMI transmit path.
//   - DEF_* : 640x480@60 timing constants (pixels / lines)
//   - timing_t : bundle of the three raw timing strobes (de, hs, vs)
//   - total_of() : sums the four segments of a horizontal or vertical period
package video_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Widest period the 12-bit x/y counters can represent
    localparam int unsigned MAX_TOTAL = 4096;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } timing_t;

    function automatic int unsigned total_of(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// sync_delay: PIPE-deep shift register of timing_t, advancing only when ce is high.
//   clk, resetn : clock and asynchronous active-low reset (stages clear to deasserted)
//   ce          : pixel-rate enable; the line shifts by one stage per enabled cycle
//   din / dout  : raw timing in, delayed timing out
// With PIPE = 0 the block collapses to a plain wire.
module sync_delay
    import video_pkg::*;
#(
    parameter int unsigned PIPE = 0
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    ce,
    input  timing_t din,
    output timing_t dout
);

    if (PIPE == 0) begin : g_wire
        // Clock/reset/enable are intentionally unused in the zero-depth case
        logic unused_ctrl;
        assign unused_ctrl = clk ^ resetn ^ ce;
        assign dout = din;
    end else begin : g_shift
        timing_t stage [PIPE];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < int'(PIPE); i++) begin
                    stage[i] <= '0;
                end
            end else if (ce) begin
                stage[0] <= din;
                for (int i = 1; i < int'(PIPE); i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[PIPE-1];
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: raster timing generator and registered pixel output for the HDMI path.
//   clk, resetn        : single system clock, asynchronous active-low reset
//   pix_ce             : pixel-rate enable, one pixel step per enabled cycle
//   r, g, b            : colour returned by the upstream picture stage for (x, y)
//   x, y               : current horizontal / vertical count (counter registers)
//   hdmi_d             : {r,g,b} while active, 0 while blanked
//   hdmi_de            : data enable
//   hdmi_hs, hdmi_vs   : syncs, pin level equals HS_POL / VS_POL while asserted
//   frame_start        : one-clock pulse after the counters wrap to (0,0)
// The raw strobes are delayed by PIPE pixel steps to line up with an upstream stage of
// PIPE steps latency, then registered together with the sampled colour.
module hdmi_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE     = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_ce,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [23:0] hdmi_d,
    output logic        hdmi_de,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_size_check
        $error("hdmi_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Decode bounds are 13 bits wide so a 4096-wide segment edge stays representable
    localparam logic [12:0] H_DE_END = 13'(H_ACTIVE);
    localparam logic [12:0] H_HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_DE_END = 13'(V_ACTIVE);
    localparam logic [12:0] V_VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    // ---------------------------------------------------------------- counters
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        h_wrap, v_wrap;
    logic        frame_start_d;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_wrap ? 12'd0 : h_q + 12'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? 12'd0 : v_q + 12'd1;
        end
        // Pulse is produced only by a real wrap, so leaving reset at (0,0) gives none
        frame_start_d = pix_ce & h_wrap & v_wrap;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q <= 12'd0;
            v_q <= 12'd0;
        end else if (pix_ce) begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Registered every clock (not gated) so the pulse lasts exactly one clk cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_start_d;
        end
    end

    assign x = h_q;
    assign y = v_q;

    // ---------------------------------------------------------------- raw timing
    timing_t raw;
    timing_t dly;
    logic [12:0] h_ext, v_ext;

    always_comb begin
        h_ext  = {1'b0, h_q};
        v_ext  = {1'b0, v_q};
        raw.de = (h_ext < H_DE_END) && (v_ext < V_DE_END);
        raw.hs = (h_ext >= H_HS_BEG) && (h_ext < H_HS_END);
        raw.vs = (v_ext >= V_VS_BEG) && (v_ext < V_VS_END);
    end

    sync_delay #(
        .PIPE (PIPE)
    ) u_sync_delay (
        .clk    (clk),
        .resetn (resetn),
        .ce     (pix_ce),
        .din    (raw),
        .dout   (dly)
    );

    // ---------------------------------------------------------------- output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdmi_d  <= 24'h0;
            hdmi_de <= 1'b0;
            hdmi_hs <= ~HS_POL;
            hdmi_vs <= ~VS_POL;
        end else if (pix_ce) begin
            hdmi_de <= dly.de;
            hdmi_d  <= dly.de ? {r, g, b} : 24'h0;
            // XNOR with polarity: pin reads POL while asserted, !POL otherwise
            hdmi_hs <= ~(dly.hs ^ HS_POL);
            hdmi_vs <= ~(dly.vs ^ VS_POL);
        end
    end

endmodule

// File: doc/hdmi_timing_gen.md
# hdmi_timing_gen

Raster timing generator and pixel output register for the HDMI transmitter path. It runs the horizontal and vertical counters and drives the current pixel coordinate `x`/`y` to the picture stage upstream. It samples the colour returned by that stage and emits the registered, sync-aligned `hdmi_d`/`hdmi_de`/`hdmi_hs`/`hdmi_vs` to the transmitter pins. It replaces the toggled-register clock divider with a clock enable, so the whole path stays on one clock.

## Interface

Parameters:

- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: hsync width, in pixels
- `H_BP`, default 48: horizontal back porch, in pixels
- `V_ACTIVE`, default 480: visible lines
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync width, in lines
- `V_BP`, default 33: vertical back porch, in lines
- `HS_POL`, default 0: asserted level of `hdmi_hs` (0 = active-low)
- `VS_POL`, default 0: asserted level of `hdmi_vs`
- `PIPE`, default 0: upstream pixel latency, in pixel steps, from `x`/`y` to valid `r`/`g`/`b`

Ports:

- `clk` in 1: system clock
- `resetn` in 1: reset; asynchronous assert, active-low
- `pix_ce` in 1: pixel-rate enable; one pixel step per cycle in which it is high
- `r`, `g`, `b` in 8 each: colour from the upstream picture stage
- `x` out 12: current horizontal count, driven straight from the counter register
- `y` out 12: current vertical count, driven straight from the counter register
- `hdmi_d` out 24: `{r,g,b}` while active, 0 while blanked
- `hdmi_de` out 1: data enable
- `hdmi_hs` out 1: horizontal sync
- `hdmi_vs` out 1: vertical sync
- `frame_start` out 1: one-cycle pulse at the start of each frame

## Operation

**Counters**
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` is formed the same way.
- `h` advances by 1 on each cycle with `pix_ce` high. When `h = H_TOTAL-1` it wraps to 0 and `v` advances.
- `v` wraps to 0 after `V_TOTAL-1`. `v` changes only on the same cycle that `h` wraps.
- When `pix_ce` is low, every register in the block holds its value.
- `x = h` and `y = v`, zero-extended to 12 bits. `H_TOTAL` and `V_TOTAL` must both be ≤ 4096; an elaboration-time check enforces this.

**Raw timing, decoded from `h`/`v`**
- `de_raw = (h < H_ACTIVE) && (v < V_ACTIVE)`.
- `hs_raw` is asserted for `H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC`.
- `vs_raw` is asserted for `V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC`. `vs_raw` depends on `v` only, not `h`.

**Alignment**
- `de_raw`, `hs_raw` and `vs_raw` pass through a `PIPE`-deep delay line that advances on `pix_ce`.
- The output register then captures the following on a `pix_ce` cycle:
  - `hdmi_de` ← delayed `de`
  - `hdmi_d` ← delayed `de` ? `{r,g,b}` : 24'h0
  - `hdmi_hs` ← delayed `hs` XNOR `HS_POL`, so the pin sits at `HS_POL` when sync is asserted
  - `hdmi_vs` ← delayed `vs` XNOR `VS_POL`, likewise
- `r`/`g`/`b` are sampled only in that output register. When `PIPE = 0`, the upstream stage must be combinational from `x`/`y`.

**Frame pulse**
- `frame_start` is a registered signal. It is high for exactly one `clk` cycle: the cycle after `pix_ce` moves the counters to `h = 0, v = 0`.

## Timing

- **Reset values:**
  - `h`, `v`, `x`, `y`: 0
  - `hdmi_d`: 0
  - `hdmi_de`: 0
  - `hdmi_hs`: `!HS_POL`
  - `hdmi_vs`: `!VS_POL`
  - `frame_start`: 0
  - Delay-line stages: deasserted
- **Release from reset:**
  - The first frame begins at `h = 0, v = 0` without a `frame_start` pulse.
  - The first `frame_start` pulse comes at the first wrap.
- **Latency:**
  - Outputs reflect the counter state from `PIPE+1` pixel steps earlier.
  - The first active pixel's `hdmi_de` rises on the `(PIPE+1)`th `pix_ce` after `h = 0, v = 0`.
- **Reset mid-frame:** all registers return to their reset values immediately, asynchronously, with no partial-line completion.
- **Continuous enable:** `pix_ce` tied high is legal and gives one pixel per clock.
- **End of line:** at `h = H_TOTAL-1, v = V_TOTAL-1` both counters wrap on the same `pix_ce` cycle.

## Structure

- A shared package `video_pkg` holds the 640×480 default timing constants and a `timing_t` struct bundling `de`, `hs`, `vs`.
- The natural sub-module is `sync_delay`: a `PIPE`-deep, `pix_ce`-gated shift register of `timing_t`. It must be a pass-through wire when `PIPE = 0`.

## Test plan

Use small parameters unless stated: `H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1`, so `H_TOTAL=16`, `V_TOTAL=8`.

- **Reset:** assert `resetn=0` mid-line.
  - Immediately: `x=0`, `y=0`, `hdmi_de=0`, `hdmi_hs=1`, `hdmi_vs=1`, `hdmi_d=0`.
- **Counters:** `pix_ce` tied high for 128 clocks.
  - `x` cycles 0–15.
  - `y` steps 0–7, changing only on the cycle `x` wraps.
  - `frame_start` pulses once, at clock 129.
- **`pix_ce` gating:** `pix_ce` high every 3rd clock.
  - Every count and output holds for 2 clocks between steps.
  - A full frame takes 384 clocks.
- **Data alignment:** `PIPE=2`; bench model returns `r=x`, `g=y`, `b=8'hA5` with 2-step latency.
  - `hdmi_d = {x,y,A5}` of 3 steps earlier on every `hdmi_de=1` cycle, and 0 otherwise.
  - 32 `de` cycles per frame.
- **Sync pulses:** per frame, check with default polarity and again with `HS_POL=1`, `VS_POL=1`.
  - `hdmi_hs` is low for exactly 3 steps per line, starting at delayed `h=10`.
  - `hdmi_vs` is low for exactly 32 steps, starting at delayed `v=5`.
  - With `HS_POL=1`, `VS_POL=1`, the waveforms are inverted.
- **Default parameters:** `H_TOTAL=800`, `V_TOTAL=525`.
  - 420000 steps per frame.
  - 307200 `de` cycles per frame.
